sort_batch_ctrl: RTL and testbench

- Sequencer for the pipelined even-odd sorting network. Packs a serial record stream (valid/ready) into 2^P_LOG-wide batches.
- Issues each batch to the network with a one-cycle DINEN pulse. Captures the sorted batches on DOTEN into a batch buffer, then unpacks them to a serial valid/ready output.
- The network cannot stall, so a credit counter allows an issue only when a buffer slot is reserved for the result.

---
 rtl/sort_pkg.sv | 14 +
 rtl/sn_batch_fifo.sv | 66 ++++++
 rtl/sort_batch_ctrl.sv | 114 +++++++++++
 tb/tb_sort_batch_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// sort_pkg: batch-size defaults, clog2 helper, padding record and FSM encodings
package sort_pkg;
  localparam int P_LOG_DEF = 4;
  localparam int N_DEF = 1 << P_LOG_DEF;
  localparam logic [1023:0] PAD_REC = '1;
  typedef enum logic {FILL, ISSUE} pk_state_e;
  typedef enum logic {IDLE, DRAIN} up_state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sn_batch_fifo.sv
// sn_batch_fifo: batch buffer whose count field is reserved at issue and data filled at capture
module sn_batch_fifo import sort_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int DW = 64,
  parameter int NW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic [NW-1:0] push_cnt,
  input  logic          cap,
  input  logic [DW-1:0] cap_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic          more,
  output logic [DW-1:0] head,
  output logic [NW-1:0] head_cnt
);
  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [AW-1:0] wp_q, wp_d, cp_q, cp_d, rp_q, rp_d;
  logic [LW-1:0] nres_q, nres_d, ncap_q, ncap_d;
  logic [DEPTH-1:0][DW-1:0] dat_q, dat_d;
  logic [DEPTH-1:0][NW-1:0] cnt_q, cnt_d;
  logic push_ok, cap_ok, pop_ok;
  // a capture is only taken into a slot already reserved by an issue
  assign push_ok = push && nres_q != LW'(DEPTH);
  assign cap_ok = cap && ncap_q != nres_q;
  assign pop_ok = pop && !empty;
  assign full = ncap_q == LW'(DEPTH);
  assign empty = ncap_q == '0;
  assign more = ncap_q > LW'(1);
  assign head = dat_q[rp_q];
  assign head_cnt = cnt_q[rp_q];
  always_comb begin
    dat_d = dat_q;
    cnt_d = cnt_q;
    if (cap_ok) dat_d[cp_q] = cap_data;
    if (push_ok) cnt_d[wp_q] = push_cnt;
    wp_d = wp_q + AW'(push_ok);
    cp_d = cp_q + AW'(cap_ok);
    rp_d = rp_q + AW'(pop_ok);
    nres_d = nres_q + LW'(push_ok) - LW'(pop_ok);
    ncap_d = ncap_q + LW'(cap_ok) - LW'(pop_ok);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      wp_q <= '0;
      cp_q <= '0;
      rp_q <= '0;
      nres_q <= '0;
      ncap_q <= '0;
    end else begin
      wp_q <= wp_d;
      cp_q <= cp_d;
      rp_q <= rp_d;
      nres_q <= nres_d;
      ncap_q <= ncap_d;
    end
  end
  always_ff @(posedge CLK) begin
    dat_q <= dat_d;
    cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sort_batch_ctrl.sv
// sort_batch_ctrl: packs records into batches for the sorting network and unpacks sorted results.
// Define SORT_CHK_EN to add the sticky ERR output flagging out-of-order keys within a batch.
module sort_batch_ctrl import sort_pkg::*; #(
  parameter int P_LOG = P_LOG_DEF,
  parameter int DATW = 64,
  parameter int KEYW = 32,
  parameter int BUF_DEPTH = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATW-1:0]           IN_DATA,
  input  logic                      IN_VALID,
  input  logic                      IN_LAST,
  output logic                      IN_READY,
  output logic [(DATW<<P_LOG)-1:0]  SN_DIN,
  output logic                      SN_DINEN,
  input  logic [(DATW<<P_LOG)-1:0]  SN_DOT,
  input  logic                      SN_DOTEN,
  output logic [DATW-1:0]           OUT_DATA,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic                      OUT_LAST,
  output logic [clog2(BUF_DEPTH):0] CREDITS
`ifdef SORT_CHK_EN
  ,
  output logic                      ERR
`endif
);
  localparam int N = 1 << P_LOG;
  localparam int CW = clog2(BUF_DEPTH) + 1;
  localparam int NW = P_LOG + 1;
  typedef logic [N-1:0][DATW-1:0] batch_t;
  pk_state_e pk_q, pk_d;
  up_state_e up_q, up_d;
  batch_t pack_q, pack_d, sn_din_q, sn_din_d, head;
  logic [NW-1:0] cnt_q, cnt_d, head_cnt;
  logic [P_LOG-1:0] s_q, s_d;
  logic [CW-1:0] credits_q, credits_d;
  logic sn_dinen_q, sn_dinen_d;
  logic accept, issue, hs, last, pop, full, empty, more;
  assign accept = IN_VALID && IN_READY;
  assign issue = pk_q == ISSUE && credits_q != '0;
  assign hs = up_q == DRAIN && OUT_READY;
  assign last = {1'b0, s_q} == head_cnt - NW'(1);
  assign pop = hs && last;
  assign SN_DIN = sn_din_q;
  assign SN_DINEN = sn_dinen_q;
  assign CREDITS = credits_q;
  sn_batch_fifo #(.DEPTH(BUF_DEPTH), .DW(DATW << P_LOG), .NW(NW)) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (issue),
    .push_cnt (cnt_q),
    .cap      (SN_DOTEN && !full),
    .cap_data (SN_DOT),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .more     (more),
    .head     (head),
    .head_cnt (head_cnt)
  );
  always_comb begin
    pk_d = pk_q == FILL ? (accept && (cnt_q == NW'(N-1) || IN_LAST) ? ISSUE : FILL)
                        : (issue ? FILL : ISSUE);
    up_d = up_q == IDLE ? (empty ? IDLE : DRAIN) : (pop && !more ? IDLE : DRAIN);
  end
  // cnt holds the real-record count (1..N) while waiting in ISSUE
  always_comb begin
    pack_d = pack_q;
    for (int i = 0; i < N; i++)
      pack_d[i] = accept && NW'(i) == cnt_q ? IN_DATA
                : accept && IN_LAST && NW'(i) > cnt_q ? PAD_REC[DATW-1:0] : pack_q[i];
    cnt_d = issue ? '0 : cnt_q + NW'(accept);
    sn_dinen_d = issue;
    sn_din_d = issue ? pack_q : sn_din_q;
    s_d = hs ? (last ? '0 : s_q + P_LOG'(1)) : s_q;
    credits_d = credits_q - CW'(issue) + CW'(pop);
    IN_READY = pk_q == FILL && !RST;
    OUT_VALID = up_q == DRAIN;
    OUT_LAST = OUT_VALID && last;
    OUT_DATA = head[s_q];
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      pk_q <= FILL;
      up_q <= IDLE;
      pack_q <= '0;
      cnt_q <= '0;
      s_q <= '0;
      credits_q <= CW'(BUF_DEPTH);
      sn_din_q <= '0;
      sn_dinen_q <= 1'b0;
    end else begin
      pk_q <= pk_d;
      up_q <= up_d;
      pack_q <= pack_d;
      cnt_q <= cnt_d;
      s_q <= s_d;
      credits_q <= credits_d;
      sn_din_q <= sn_din_d;
      sn_dinen_q <= sn_dinen_d;
    end
  end
`ifdef SORT_CHK_EN
  logic err_q, err_d;
  assign err_d = err_q || (hs && s_q != '0 && head[s_q][KEYW-1:0] < head[s_q - P_LOG'(1)][KEYW-1:0]);
  assign ERR = err_q;
  always_ff @(posedge CLK) begin
    if (RST) err_q <= 1'b0;
    else err_q <= err_d;
  end
`endif
endmodule

// File: tb/tb_sort_batch_ctrl.sv
// tb_sort_batch_ctrl: scoreboard bench with a behavioural fixed-latency sorting network attached
module tb_sort_batch_ctrl;
  localparam int P_LOG = 2, N = 4, DATW = 16, KEYW = 8, BUF_DEPTH = 2, LAT = 3;
  logic CLK = 0, RST = 1;
  logic [DATW-1:0] IN_DATA = '0;
  logic IN_VALID = 0, IN_LAST = 0, IN_READY;
  logic [N*DATW-1:0] SN_DIN, SN_DOT;
  logic SN_DINEN, SN_DOTEN;
  logic [DATW-1:0] OUT_DATA;
  logic OUT_VALID, OUT_LAST;
  logic OUT_READY = 1;
  logic [1:0] CREDITS;
`ifdef SORT_CHK_EN
  logic ERR;
`endif
  typedef struct {logic [DATW-1:0] d; logic l;} exp_t;
  exp_t sb[$];
  int pass_cnt = 0, total_cnt = 0, dinen_cnt = 0, stall_checks = 0;
  logic [N*DATW-1:0] last_din = '0;
  logic [N*DATW-1:0] pipe_d [LAT];
  logic pipe_v [LAT];
  bit bypass = 0, tog_done = 0, stall_prev = 0;
  logic [DATW-1:0] stall_data;

  sort_batch_ctrl #(.P_LOG(P_LOG), .DATW(DATW), .KEYW(KEYW), .BUF_DEPTH(BUF_DEPTH)) dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST),
    .IN_READY(IN_READY), .SN_DIN(SN_DIN), .SN_DINEN(SN_DINEN), .SN_DOT(SN_DOT),
    .SN_DOTEN(SN_DOTEN), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_LAST(OUT_LAST), .CREDITS(CREDITS)
`ifdef SORT_CHK_EN
    , .ERR(ERR)
`endif
  );

  always #5 CLK = ~CLK;
  initial begin
    #300000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  function automatic logic [N*DATW-1:0] net_sort(input logic [N*DATW-1:0] x, input bit byp);
    logic [DATW-1:0] r [N];
    logic [DATW-1:0] t;
    logic [N*DATW-1:0] y;
    for (int i = 0; i < N; i++) r[i] = x[i*DATW +: DATW];
    if (!byp)
      for (int i = 0; i < N-1; i++)
        for (int j = 0; j < N-1-i; j++)
          if (r[j][KEYW-1:0] > r[j+1][KEYW-1:0]) begin t = r[j]; r[j] = r[j+1]; r[j+1] = t; end
    for (int i = 0; i < N; i++) y[i*DATW +: DATW] = r[i];
    return y;
  endfunction

  // network model: fixed latency, cleared together with the controller reset
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < LAT; i++) begin pipe_v[i] <= 1'b0; pipe_d[i] <= '0; end
    end else begin
      pipe_v[0] <= SN_DINEN;
      pipe_d[0] <= net_sort(SN_DIN, bypass);
      for (int i = 1; i < LAT; i++) begin pipe_v[i] <= pipe_v[i-1]; pipe_d[i] <= pipe_d[i-1]; end
    end
  end
  assign SN_DOT = pipe_d[LAT-1];
  assign SN_DOTEN = pipe_v[LAT-1];

  always @(negedge CLK) begin
    exp_t e;
    if (RST) stall_prev = 0;
    else begin
      if (SN_DINEN) begin dinen_cnt++; last_din = SN_DIN; end
      if (stall_prev && OUT_VALID) begin
        total_cnt++; stall_checks++;
        if (OUT_DATA !== stall_data) $display("FAIL hold_stable got %h want %h", OUT_DATA, stall_data);
        else pass_cnt++;
      end
      stall_prev = OUT_VALID && !OUT_READY;
      stall_data = OUT_DATA;
      if (OUT_VALID && OUT_READY) begin
        total_cnt++;
        if (sb.size() == 0) $display("FAIL unexpected_out got %h/%b want none", OUT_DATA, OUT_LAST);
        else begin
          e = sb.pop_front();
          if (OUT_DATA !== e.d || OUT_LAST !== e.l)
            $display("FAIL out_rec got %h/%b want %h/%b", OUT_DATA, OUT_LAST, e.d, e.l);
          else pass_cnt++;
        end
      end
    end
  end

  task automatic send_keys(input int k0, k1, k2, k3, input int n, input bit lst);
    logic [DATW-1:0] r [N];
    logic [DATW-1:0] s [N];
    logic [DATW-1:0] t;
    int k [N];
    int g;
    k = '{k0, k1, k2, k3};
    for (int i = 0; i < N; i++) begin r[i] = {8'($urandom_range(0, 255)), 8'(k[i])}; s[i] = r[i]; end
    if (!bypass)
      for (int i = 0; i < n-1; i++)
        for (int j = 0; j < n-1-i; j++)
          if (s[j][KEYW-1:0] > s[j+1][KEYW-1:0]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    for (int i = 0; i < n; i++) sb.push_back('{s[i], i == n-1});
    for (int i = 0; i < n; i++) begin
      IN_DATA = r[i]; IN_VALID = 1; IN_LAST = lst && i == n-1;
      g = 0;
      @(negedge CLK);
      while (!IN_READY && g < 200) begin @(negedge CLK); g++; end
      if (!IN_READY) begin total_cnt++; $display("FAIL in_ready_timeout got 0 want 1"); end
      @(posedge CLK); #1;
    end
    IN_VALID = 0; IN_LAST = 0;
  endtask

  task automatic wait_drain(input string name);
    int g = 0;
    @(negedge CLK);
    while ((sb.size() != 0 || OUT_VALID) && g < 400) begin @(negedge CLK); g++; end
    total_cnt++;
    if (sb.size() != 0) $display("FAIL %s_drain got %0d pending want 0", name, sb.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    RST = 1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total_cnt += 6;
    if (IN_READY !== 1'b0) $display("FAIL rst_in_ready got %b want 0", IN_READY); else pass_cnt++;
    if (SN_DINEN !== 1'b0) $display("FAIL rst_dinen got %b want 0", SN_DINEN); else pass_cnt++;
    if (SN_DIN !== '0) $display("FAIL rst_din got %h want 0", SN_DIN); else pass_cnt++;
    if (OUT_VALID !== 1'b0) $display("FAIL rst_out_valid got %b want 0", OUT_VALID); else pass_cnt++;
    if (OUT_LAST !== 1'b0) $display("FAIL rst_out_last got %b want 0", OUT_LAST); else pass_cnt++;
    if (CREDITS !== 2'd2) $display("FAIL rst_credits got %0d want 2", CREDITS); else pass_cnt++;
    @(posedge CLK); #1 RST = 0;
    @(negedge CLK);
    total_cnt++;
    if (IN_READY !== 1'b1) $display("FAIL post_rst_in_ready got %b want 1", IN_READY); else pass_cnt++;
  endtask

  task automatic test_full();
    int d0;
    @(posedge CLK); #1;
    d0 = dinen_cnt;
    send_keys(9, 3, 7, 1, 4, 0);
    wait_drain("full");
    total_cnt += 2;
    if (dinen_cnt - d0 !== 1) $display("FAIL full_dinen got %0d want 1", dinen_cnt - d0); else pass_cnt++;
    if (CREDITS !== 2'd2) $display("FAIL full_credits got %0d want 2", CREDITS); else pass_cnt++;
  endtask

  task automatic test_partial();
    @(posedge CLK); #1;
    send_keys(5, 2, 0, 0, 2, 1);
    wait_drain("partial");
    total_cnt += 3;
    if (last_din[2*DATW +: DATW] !== 16'hFFFF) $display("FAIL pad_slot2 got %h want ffff", last_din[2*DATW +: DATW]); else pass_cnt++;
    if (last_din[3*DATW +: DATW] !== 16'hFFFF) $display("FAIL pad_slot3 got %h want ffff", last_din[3*DATW +: DATW]); else pass_cnt++;
    if (last_din[KEYW-1:0] !== 8'd5) $display("FAIL partial_slot0 got %h want 05", last_din[KEYW-1:0]); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int d0;
    @(posedge CLK); #1;
    OUT_READY = 0;
    d0 = dinen_cnt;
    send_keys(4, 8, 2, 6, 4, 0);
    send_keys(11, 10, 13, 12, 4, 0);
    send_keys(30, 20, 40, 25, 4, 0);
    repeat (10) @(negedge CLK);
    total_cnt += 4;
    if (CREDITS !== 2'd0) $display("FAIL bp_credits got %0d want 0", CREDITS); else pass_cnt++;
    if (IN_READY !== 1'b0) $display("FAIL bp_in_ready got %b want 0", IN_READY); else pass_cnt++;
    if (dinen_cnt - d0 !== 2) $display("FAIL bp_dinen got %0d want 2", dinen_cnt - d0); else pass_cnt++;
    if (OUT_VALID !== 1'b1) $display("FAIL bp_out_valid got %b want 1", OUT_VALID); else pass_cnt++;
    @(posedge CLK); #1 OUT_READY = 1;
    wait_drain("bp");
    total_cnt += 2;
    if (dinen_cnt - d0 !== 3) $display("FAIL bp_dinen_total got %0d want 3", dinen_cnt - d0); else pass_cnt++;
    if (CREDITS !== 2'd2) $display("FAIL bp_credits_end got %0d want 2", CREDITS); else pass_cnt++;
  endtask

  task automatic test_toggle();
    int s0;
    @(posedge CLK); #1;
    s0 = stall_checks;
    tog_done = 0;
    fork
      begin
        int g = 0;
        while (!tog_done && g < 2000) begin @(posedge CLK); #1 OUT_READY = ~OUT_READY; g++; end
      end
      begin
        send_keys(21, 17, 19, 16, 4, 0);
        send_keys(33, 35, 31, 34, 4, 1);
        wait_drain("toggle");
        tog_done = 1;
      end
    join
    @(posedge CLK); #1 OUT_READY = 1;
    total_cnt++;
    if (stall_checks <= s0) $display("FAIL toggle_stalls got %0d want >0", stall_checks - s0); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int d0, g;
    bit seen;
    @(posedge CLK); #1;
    d0 = dinen_cnt;
    send_keys(50, 40, 60, 45, 4, 0);
    g = 0;
    while (dinen_cnt == d0 && g < 100) begin @(negedge CLK); g++; end
    @(posedge CLK); #1 RST = 1;
    sb.delete();
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    @(negedge CLK);
    total_cnt += 3;
    if (OUT_VALID !== 1'b0) $display("FAIL rmid_out_valid got %b want 0", OUT_VALID); else pass_cnt++;
    if (CREDITS !== 2'd2) $display("FAIL rmid_credits got %0d want 2", CREDITS); else pass_cnt++;
    if (IN_READY !== 1'b1) $display("FAIL rmid_in_ready got %b want 1", IN_READY); else pass_cnt++;
    seen = 0;
    repeat (15) begin @(negedge CLK); if (OUT_VALID) seen = 1; end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL rmid_stale got %b want 0", seen); else pass_cnt++;
    @(posedge CLK); #1;
    send_keys(3, 2, 1, 4, 4, 0);
    wait_drain("rmid");
  endtask

`ifdef SORT_CHK_EN
  task automatic test_chk();
    int g = 0;
    @(posedge CLK); #1;
    total_cnt++;
    if (ERR !== 1'b0) $display("FAIL chk_err_init got %b want 0", ERR); else pass_cnt++;
    bypass = 1;
    send_keys(1, 4, 2, 8, 4, 0);
    while (!(OUT_VALID && OUT_READY && OUT_DATA[KEYW-1:0] == 8'd2) && g < 200) begin @(negedge CLK); g++; end
    total_cnt += 2;
    if (ERR !== 1'b0) $display("FAIL chk_err_before got %b want 0", ERR); else pass_cnt++;
    @(negedge CLK);
    if (ERR !== 1'b1) $display("FAIL chk_err_set got %b want 1", ERR); else pass_cnt++;
    wait_drain("chk");
    bypass = 0;
    @(posedge CLK); #1;
    send_keys(7, 5, 6, 9, 4, 0);
    wait_drain("chk2");
    total_cnt++;
    if (ERR !== 1'b1) $display("FAIL chk_err_sticky got %b want 1", ERR); else pass_cnt++;
    @(posedge CLK); #1 RST = 1;
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    @(negedge CLK);
    total_cnt++;
    if (ERR !== 1'b0) $display("FAIL chk_err_rst got %b want 0", ERR); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_full();
    test_partial();
    test_backpressure();
    test_toggle();
    test_reset_mid();
`ifdef SORT_CHK_EN
    test_chk();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
